// File: rtl/imem_pkg.sv
// rtl/imem_pkg.sv - shared types and constants for the instruction-memory arbiter
package imem_pkg;

    typedef enum logic {
        ST_BOOT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    typedef enum logic {
        REQ_FETCH = 1'b0,
        REQ_LOAD  = 1'b1
    } requester_t;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    // Misaligned, or a word that would run past the end of memory.
    function automatic logic addr_illegal(input logic [31:0] addr, input int unsigned size);
        return (addr[1:0] != 2'b00) || (addr >= (32'(size) - 32'd3));
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// rtl/rr_arb2.sv - two-requester round-robin grant with last-granted pointer
module rr_arb2
    import imem_pkg::*;
(
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_req_f,
    input  logic i_req_l,
    output logic o_gnt_f,
    output logic o_gnt_l
);

    requester_t last_q;

    always_comb begin
        o_gnt_f = i_req_f && (!i_req_l || (last_q == REQ_LOAD));
        o_gnt_l = i_req_l && (!i_req_f || (last_q == REQ_FETCH));
    end

    // Pointer holds the last winner; resetting it to LOAD favours fetch first.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            last_q <= REQ_LOAD;
        end else if (o_gnt_f) begin
            last_q <= REQ_FETCH;
        end else if (o_gnt_l) begin
            last_q <= REQ_LOAD;
        end
    end

endmodule

// File: rtl/imem_arbiter.sv
// rtl/imem_arbiter.sv - boot/run arbitration of CPU fetch and loader onto one memory port
module imem_arbiter
    import imem_pkg::*;
#(
    parameter int SIZE = 512,
    parameter int AW   = $clog2(SIZE)
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_boot_done,
    input  logic          i_f_req,
    input  logic [31:0]   i_f_addr,
    output logic          o_f_gnt,
    output logic          o_f_rvalid,
    output logic [31:0]   o_f_rdata,
    output logic          o_f_err,
    input  logic          i_l_req,
    input  logic          i_l_we,
    input  logic [31:0]   i_l_addr,
    input  logic [31:0]   i_l_wdata,
    output logic          o_l_gnt,
    output logic          o_l_rvalid,
    output logic [31:0]   o_l_rdata,
    output logic          o_l_err,
    output logic          o_m_en,
    output logic          o_m_we,
    output logic [AW-1:0] o_m_addr,
    output logic [31:0]   o_m_wdata,
    input  logic [31:0]   i_m_rdata
);

    state_t     state_q, state_d;
    logic       rst_q;
    logic       blocked;
    logic       req_f, req_l;
    logic       gnt_f, gnt_l;
    logic [31:0] sel_addr;
    logic       sel_err;
    logic       rsp_live;
    logic [31:0] rsp_data;

    logic       rv_q;
    requester_t owner_q;
    logic       err_q;
    logic       we_q;

    always_ff @(posedge i_clk) begin
        rst_q <= i_rst;
        if (i_rst) begin
            state_q <= ST_BOOT;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if ((state_q == ST_BOOT) && i_boot_done) begin
            state_d = ST_RUN;
        end
    end

    // No grants during reset nor in the cycle right after it.
    assign blocked = i_rst || rst_q;
    assign req_f   = i_f_req && (state_q == ST_RUN) && !blocked;
    assign req_l   = i_l_req && !blocked;

    rr_arb2 u_rr (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_req_f (req_f),
        .i_req_l (req_l),
        .o_gnt_f (gnt_f),
        .o_gnt_l (gnt_l)
    );

    assign o_f_gnt   = gnt_f;
    assign o_l_gnt   = gnt_l;
    assign sel_addr  = gnt_l ? i_l_addr : i_f_addr;
    assign sel_err   = addr_illegal(sel_addr, SIZE);
    assign o_m_en    = (gnt_f || gnt_l) && !sel_err;
    assign o_m_we    = gnt_l && i_l_we && !sel_err;
    assign o_m_addr  = sel_addr[AW-1:0];
    assign o_m_wdata = gnt_l ? i_l_wdata : 32'd0;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            rv_q    <= 1'b0;
            owner_q <= REQ_FETCH;
            err_q   <= 1'b0;
            we_q    <= 1'b0;
        end else begin
            rv_q    <= gnt_f || gnt_l;
            owner_q <= gnt_l ? REQ_LOAD : REQ_FETCH;
            err_q   <= sel_err;
            we_q    <= gnt_l && i_l_we;
        end
    end

    // A response pending across a reset edge is dropped rather than emitted.
    assign rsp_live = rv_q && !i_rst;

    always_comb begin
        rsp_data = i_m_rdata;
        if (err_q) begin
            rsp_data = (owner_q == REQ_FETCH) ? NOP_INSTR : 32'd0;
        end else if (we_q) begin
            rsp_data = 32'd0;
        end
    end

    assign o_f_rvalid = rsp_live && (owner_q == REQ_FETCH);
    assign o_l_rvalid = rsp_live && (owner_q == REQ_LOAD);
    assign o_f_rdata  = o_f_rvalid ? rsp_data : 32'd0;
    assign o_l_rdata  = o_l_rvalid ? rsp_data : 32'd0;
    assign o_f_err    = o_f_rvalid && err_q;
    assign o_l_err    = o_l_rvalid && err_q;

endmodule

// File: tb/tb_imem_arbiter.sv
// tb/tb_imem_arbiter.sv - randomized scoreboard bench for imem_arbiter
module tb_imem_arbiter;

    localparam int SIZE = 512;
    localparam int AW   = $clog2(SIZE);
    localparam int NW   = SIZE / 4;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          boot_done = 1'b0;
    logic          f_req = 1'b0;
    logic [31:0]   f_addr = '0;
    logic          f_gnt, f_rvalid, f_err;
    logic [31:0]   f_rdata;
    logic          l_req = 1'b0;
    logic          l_we = 1'b0;
    logic [31:0]   l_addr = '0;
    logic [31:0]   l_wdata = '0;
    logic          l_gnt, l_rvalid, l_err;
    logic [31:0]   l_rdata;
    logic          m_en, m_we;
    logic [AW-1:0] m_addr;
    logic [31:0]   m_wdata;
    logic [31:0]   m_rdata;

    imem_arbiter #(.SIZE(SIZE), .AW(AW)) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_boot_done (boot_done),
        .i_f_req     (f_req),
        .i_f_addr    (f_addr),
        .o_f_gnt     (f_gnt),
        .o_f_rvalid  (f_rvalid),
        .o_f_rdata   (f_rdata),
        .o_f_err     (f_err),
        .i_l_req     (l_req),
        .i_l_we      (l_we),
        .i_l_addr    (l_addr),
        .i_l_wdata   (l_wdata),
        .o_l_gnt     (l_gnt),
        .o_l_rvalid  (l_rvalid),
        .o_l_rdata   (l_rdata),
        .o_l_err     (l_err),
        .o_m_en      (m_en),
        .o_m_we      (m_we),
        .o_m_addr    (m_addr),
        .o_m_wdata   (m_wdata),
        .i_m_rdata   (m_rdata)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    // Memory the DUT talks to: one-cycle read latency.
    bit [31:0] mem [NW];
    always @(posedge clk) begin
        if (m_en) begin
            if (m_we) mem[m_addr[AW-1:2]] <= m_wdata;
            else      m_rdata <= mem[m_addr[AW-1:2]];
        end
    end

    typedef struct {
        int          cyc;
        logic [31:0] data;
        logic        err;
    } rsp_t;

    rsp_t      fq[$];
    rsp_t      lq[$];
    bit [31:0] ref_mem [NW];

    int vectors = 0;
    int miscompares = 0;

    bit m_run = 0;
    bit m_last_f = 0;
    bit m_post = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s @cyc %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    function automatic bit bad_addr(input logic [31:0] a);
        return (a[1:0] != 2'b00) || (a >= SIZE - 3);
    endfunction

    task automatic step(input bit r, input bit bd,
                        input bit fr, input logic [31:0] fa,
                        input bit lr, input bit lwe, input logic [31:0] la, input logic [31:0] lwd,
                        output bit gf, output bit gl);
        bit blk, fe, le, men;
        logic [31:0] d;
        @(posedge clk);
        #1;
        rst = r; boot_done = bd;
        f_req = fr; f_addr = fa;
        l_req = lr; l_we = lwe; l_addr = la; l_wdata = lwd;
        if (r) begin
            fq.delete();
            lq.delete();
        end
        blk = r || m_post;
        gf = 0; gl = 0;
        if (!blk) begin
            if (fr && m_run && lr) begin
                gf = !m_last_f;
                gl = m_last_f;
            end else begin
                gf = fr && m_run;
                gl = lr;
            end
        end
        fe = bad_addr(fa);
        le = bad_addr(la);
        men = (gf && !fe) || (gl && !le);
        @(negedge clk);
        chk("f_gnt", {31'd0, f_gnt}, {31'd0, gf});
        chk("l_gnt", {31'd0, l_gnt}, {31'd0, gl});
        chk("m_en", {31'd0, m_en}, {31'd0, men});
        if (men) begin
            chk("m_addr", {{(32-AW){1'b0}}, m_addr}, {{(32-AW){1'b0}}, (gl ? la[AW-1:0] : fa[AW-1:0])});
            chk("m_we", {31'd0, m_we}, {31'd0, gl && lwe});
            if (gl && lwe) chk("m_wdata", m_wdata, lwd);
        end
        if (blk) begin
            chk("rst_f_rdata", f_rdata, 32'd0);
            chk("rst_l_rdata", l_rdata, 32'd0);
            chk("rst_f_err", {31'd0, f_err}, 32'd0);
            chk("rst_l_err", {31'd0, l_err}, 32'd0);
        end
        if (gf) begin
            d = fe ? NOP : ref_mem[fa[AW-1:2]];
            fq.push_back('{cyc + 1, d, fe});
        end
        if (gl) begin
            d = (le || lwe) ? 32'd0 : ref_mem[la[AW-1:2]];
            lq.push_back('{cyc + 1, d, le});
            if (!le && lwe) ref_mem[la[AW-1:2]] = lwd;
        end
        if (r) begin
            m_run = 0; m_last_f = 0; m_post = 1;
        end else begin
            m_post = 0;
            if (bd) m_run = 1;
            if (gf) m_last_f = 1;
            else if (gl) m_last_f = 0;
        end
    endtask

    // Monitor: every cycle, each port must show exactly the response scheduled for it.
    initial begin
        rsp_t e;
        wait (cyc >= 1);
        forever begin
            @(negedge clk);
            #1;
            if (fq.size() > 0 && fq[0].cyc == cyc) begin
                e = fq.pop_front();
                chk("f_rvalid", {31'd0, f_rvalid}, 32'd1);
                chk("f_rdata", f_rdata, e.data);
                chk("f_err", {31'd0, f_err}, {31'd0, e.err});
            end else begin
                chk("f_rvalid_idle", {31'd0, f_rvalid}, 32'd0);
            end
            if (lq.size() > 0 && lq[0].cyc == cyc) begin
                e = lq.pop_front();
                chk("l_rvalid", {31'd0, l_rvalid}, 32'd1);
                chk("l_rdata", l_rdata, e.data);
                chk("l_err", {31'd0, l_err}, {31'd0, e.err});
            end else begin
                chk("l_rvalid_idle", {31'd0, l_rvalid}, 32'd0);
            end
        end
    end

    function automatic logic [31:0] rnd_addr();
        case ($urandom_range(0, 9))
            0: return 32'($urandom_range(0, SIZE - 1)) | 32'd1;
            1: return 32'(SIZE) + 32'($urandom_range(0, 63) * 4);
            2: return 32'(SIZE - 4);
            3: return 32'(SIZE - 3);
            default: return 32'($urandom_range(0, 15) * 4);
        endcase
    endfunction

    initial begin
        bit gf, gl;
        bit pf, pl, pwe;
        logic [31:0] pfa, pla, pwd;

        step(1, 0, 0, 0, 0, 0, 0, 0, gf, gl);
        step(1, 0, 0, 0, 0, 0, 0, 0, gf, gl);
        step(0, 0, 1, 32'h0, 0, 0, 0, 0, gf, gl);
        step(0, 0, 1, 32'h0, 0, 0, 0, 0, gf, gl);
        step(0, 0, 0, 0, 1, 1, 32'h4, 32'hDEAD_BEEF, gf, gl);
        step(0, 1, 0, 0, 0, 0, 0, 0, gf, gl);
        step(0, 0, 1, 32'h4, 0, 0, 0, 0, gf, gl);
        step(0, 0, 0, 0, 0, 0, 0, 0, gf, gl);

        step(1, 0, 0, 0, 0, 0, 0, 0, gf, gl);
        step(0, 0, 0, 0, 0, 0, 0, 0, gf, gl);
        step(0, 1, 0, 0, 0, 0, 0, 0, gf, gl);
        for (int i = 0; i < 4; i++)
            step(0, 0, 1, 32'h4, 1, 0, 32'h4, 0, gf, gl);

        step(0, 0, 1, 32'h2, 0, 0, 0, 0, gf, gl);
        step(0, 0, 1, 32'(SIZE), 0, 0, 0, 0, gf, gl);

        step(0, 0, 0, 0, 1, 1, 32'h8, 32'h1234_5678, gf, gl);
        step(0, 0, 1, 32'h8, 0, 0, 0, 0, gf, gl);

        step(0, 0, 1, 32'h0, 0, 0, 0, 0, gf, gl);
        step(1, 0, 1, 32'h0, 0, 0, 0, 0, gf, gl);
        step(0, 0, 1, 32'h0, 0, 0, 0, 0, gf, gl);
        step(0, 0, 1, 32'h0, 0, 0, 0, 0, gf, gl);

        pf = 0; pl = 0; pwe = 0; pfa = 0; pla = 0; pwd = 0;
        for (int i = 0; i < 2000; i++) begin
            if (!pf && $urandom_range(0, 3) != 0) begin
                pf = 1; pfa = rnd_addr();
            end
            if (!pl && $urandom_range(0, 2) == 0) begin
                pl = 1; pla = rnd_addr(); pwe = $urandom_range(0, 1) == 1; pwd = $urandom;
            end
            step($urandom_range(0, 199) == 0, $urandom_range(0, 19) == 0,
                 pf, pfa, pl, pwe, pla, pwd, gf, gl);
            if (gf) pf = 0;
            if (gl) pl = 0;
        end

        for (int i = 0; i < 3; i++)
            step(0, 0, 0, 0, 0, 0, 0, 0, gf, gl);
        chk("drain", 32'(fq.size() + lq.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/imem_arbiter.md
IMEM_ARBITER -- requirements
Module: imem_arbiter

Interface
REQ-001 Parameter SIZE, default 512: instruction memory size in bytes; power of two, at least 8.
REQ-002 Parameter AW, default $clog2(SIZE): byte-address width presented to memory.
REQ-003 i_clk  in  1  single clock; all logic on its rising edge.
REQ-004 i_rst  in  1  reset, synchronous, active-high.
REQ-005 i_boot_done  in  1  one-cycle pulse from the loader ending the BOOT phase.
REQ-006 i_f_req / i_f_addr  in  1 / 32  CPU fetch request and byte address.
REQ-007 o_f_gnt  out  1  fetch request accepted this cycle.
REQ-008 o_f_rvalid / o_f_rdata / o_f_err  out  1 / 32 / 1  fetch response, data and error flag.
REQ-009 i_l_req / i_l_we / i_l_addr / i_l_wdata  in  1 / 1 / 32 / 32  loader request: write-enable, byte address, write word.
REQ-010 o_l_gnt  out  1  loader request accepted this cycle.
REQ-011 o_l_rvalid / o_l_rdata / o_l_err  out  1 / 32 / 1  loader response, data and error flag.
REQ-012 o_m_en / o_m_we / o_m_addr / o_m_wdata  out  1 / 1 / AW / 32  memory command.
REQ-013 i_m_rdata  in  32  memory read word, valid exactly one cycle after o_m_en with o_m_we low.

Function
REQ-014 States: BOOT, RUN; reset enters BOOT.
REQ-015 BOOT: only the loader is granted; i_f_req is never granted.
REQ-016 i_boot_done in BOOT moves to RUN on the next cycle; in RUN it is ignored.
REQ-017 RUN: round-robin between fetch and loader; when both request, the one not granted last wins; a lone requester wins every cycle.
REQ-018 The round-robin pointer resets to favour fetch and updates only on a grant.
REQ-019 At most one grant per cycle; a grant is combinational in the same cycle as its request.
REQ-020 A granted request whose address has bits [1:0] nonzero, or is at least SIZE-3, is an error: no memory command is issued.
REQ-021 A granted legal request drives o_m_en=1 in that cycle with o_m_addr=addr[AW-1:0]; o_m_we=i_l_we for the loader and 0 for fetch.
REQ-022 Every grant yields exactly one response one cycle later on the granted requester's port, including errors and writes.
REQ-023 Read response: rdata=i_m_rdata, err=0; write response: rdata=0, err=0.
REQ-024 Error response: fetch rdata=32'h00000013 (NOP), loader rdata=0; err=1.
REQ-025 Back-to-back grants are allowed every cycle; response ownership is tracked by a registered owner bit plus a registered valid bit.
REQ-026 A loader write followed by a fetch read of the same address in the next cycle returns the new data (write-before-read ordering relies on the memory's one-cycle latency).
REQ-027 Requesters hold req and address until granted; the arbiter does not buffer ungranted requests.
REQ-028 o_*_rvalid is high for exactly one cycle per grant, never on both ports in the same cycle.

Reset
REQ-029 i_rst high for one edge: state=BOOT, pointer=fetch, no pending response.
REQ-030 During reset and one cycle after: all gnt, rvalid, err and o_m_en are 0; rdata outputs are 0.
REQ-031 Reset mid-transaction discards the pending response; no rvalid is emitted for it.

Structure
REQ-032 Package imem_pkg holds the state enum, the requester enum (REQ_FETCH, REQ_LOAD) and the constant NOP_INSTR=32'h00000013.
REQ-033 Sub-module rr_arb2 holds the two-requester round-robin grant and pointer; imem_arbiter holds the FSM, error checks and response routing.

Verification
REQ-034 Reset, fetch req at 0x0 in BOOT -> o_f_gnt stays 0; loader writes 0xDEADBEEF to 0x4 -> o_m_we=1, o_m_addr=4, o_l_rvalid=1 next cycle with err=0.
REQ-035 i_boot_done pulse, then fetch at 0x4 -> o_f_gnt=1, o_f_rvalid next cycle, o_f_rdata=0xDEADBEEF.
REQ-036 Both requesting continuously in RUN -> grants alternate F,L,F,L starting with fetch after reset; four responses, each on the correct port.
REQ-037 Fetch at 0x2 and fetch at SIZE -> no o_m_en; o_f_err=1, o_f_rdata=0x00000013.
REQ-038 Loader writes 0x12345678 to 0x8, fetch at 0x8 granted next cycle -> o_f_rdata=0x12345678.
REQ-039 i_rst asserted the cycle after a fetch grant -> no o_f_rvalid; state=BOOT, fetch blocked.
